// File: rtl/mac_tx_pkg.sv
// mac_tx_pkg: shared FSM state encoding and MII framing constants for the TX FIFO read scheduler.
package mac_tx_pkg;

   localparam int unsigned PREAMBLE_NIBBLES = 15;
   localparam logic [3:0]  PREAMBLE_NIBBLE  = 4'h5;
   localparam logic [3:0]  SFD_NIBBLE       = 4'hD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_ABORT,
      ST_DRAIN,
      ST_IFG
   } tx_state_t;

endpackage

// File: rtl/mac_tx_fifo_ctrl_if.sv
// mac_tx_fifo_ctrl_if: commit/FIFO/MII/status bundle of the TX FIFO read scheduler.
// Optional MAC_TX_CTRL_STATS_EN adds the frames_sent/underruns counters.
interface mac_tx_fifo_ctrl_if #(
   parameter int unsigned LEN_WIDTH = 12
);
   logic                 frame_commit;
   logic [LEN_WIDTH-1:0] frame_length;
   logic                 queue_full;
   logic                 fifo_empty;
   logic [3:0]           fifo_data;
   logic                 fifo_read_enable;
   logic [3:0]           tx_data;
   logic                 tx_enable;
   logic                 tx_error;
   logic                 busy;
   logic                 status_clear;
   logic                 underrun;
   logic                 overflow;
`ifdef MAC_TX_CTRL_STATS_EN
   logic [15:0]          frames_sent;
   logic [15:0]          underruns;
`endif

   // Scheduler side.
   modport master (
      input  frame_commit, frame_length, fifo_empty, fifo_data, status_clear,
`ifdef MAC_TX_CTRL_STATS_EN
      output frames_sent, underruns,
`endif
      output queue_full, fifo_read_enable, tx_data, tx_enable, tx_error,
             busy, underrun, overflow
   );

   // Environment side: FIFO write logic, MII pins, host status.
   modport slave (
      output frame_commit, frame_length, fifo_empty, fifo_data, status_clear,
`ifdef MAC_TX_CTRL_STATS_EN
      input  frames_sent, underruns,
`endif
      input  queue_full, fifo_read_enable, tx_data, tx_enable, tx_error,
             busy, underrun, overflow
   );

endinterface

// File: rtl/mac_tx_len_queue.sv
// mac_tx_len_queue: small synchronous FIFO of committed frame lengths with full/empty flags.
module mac_tx_len_queue #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Length storage; no reset needed, occupancy is tracked by count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy update; simultaneous push and pop keep the count.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mac_tx_fifo_ctrl.sv
// mac_tx_fifo_ctrl: MAC TX nibble FIFO read scheduler. Sends preamble, SFD, frame data and IFG
// to the MII; aborts on FIFO underrun and drains the rest of the frame.
// Optional MAC_TX_CTRL_STATS_EN adds saturating frames_sent/underruns counters.
module mac_tx_fifo_ctrl #(
   parameter int unsigned LEN_WIDTH       = 12,
   parameter int unsigned LEN_QUEUE_DEPTH = 4,
   parameter int unsigned IFG_NIBBLES     = 24
) (
   input  logic               clock,
   input  logic               reset_n,
   mac_tx_fifo_ctrl_if.master bus
);
   import mac_tx_pkg::*;

   localparam int unsigned CNT_W = $clog2(IFG_NIBBLES + PREAMBLE_NIBBLES + 1);

   tx_state_t            state, state_next;
   logic [LEN_WIDTH-1:0] rem, rem_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [LEN_WIDTH-1:0] q_head;
   logic                 q_full, q_empty, q_push, q_pop;
   logic                 commit_valid, overflow_evt, abort_evt, start_ok, rd;
   logic                 underrun_q, overflow_q;

   assign commit_valid = bus.frame_commit && (bus.frame_length != '0);
   assign q_push       = commit_valid && (!q_full || q_pop);
   assign overflow_evt = commit_valid && q_full && !q_pop;
   assign start_ok     = !q_empty && !bus.fifo_empty;

   mac_tx_len_queue #(
      .WIDTH (LEN_WIDTH),
      .DEPTH (LEN_QUEUE_DEPTH)
   ) u_len_queue (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (q_push),
      .push_data (bus.frame_length),
      .pop       (q_pop),
      .pop_data  (q_head),
      .full      (q_full),
      .empty     (q_empty)
   );

   // State, remaining-length and preamble/IFG counter registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         rem   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         rem   <= rem_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state, FIFO pop and MII output decode.
   always_comb begin
      state_next = state;
      rem_next   = rem;
      cnt_next   = cnt;
      q_pop      = 1'b0;
      rd         = 1'b0;
      abort_evt  = 1'b0;
      bus.tx_data   = '0;
      bus.tx_enable = 1'b0;
      bus.tx_error  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               q_pop      = 1'b1;
               rem_next   = q_head;
               cnt_next   = '0;
               state_next = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            bus.tx_enable = 1'b1;
            bus.tx_data   = PREAMBLE_NIBBLE;
            if (cnt == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
               cnt_next   = '0;
               state_next = ST_SFD;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         ST_SFD: begin
            bus.tx_enable = 1'b1;
            bus.tx_data   = SFD_NIBBLE;
            if (!bus.fifo_empty) begin
               rd         = 1'b1;
               rem_next   = rem - LEN_WIDTH'(1);
               state_next = ST_DATA;
            end else begin
               abort_evt  = 1'b1;
               state_next = ST_ABORT;
            end
         end
         ST_DATA: begin
            bus.tx_enable = 1'b1;
            bus.tx_data   = bus.fifo_data;
            if (rem == '0) begin
               cnt_next   = '0;
               state_next = ST_IFG;
            end else if (!bus.fifo_empty) begin
               rd       = 1'b1;
               rem_next = rem - LEN_WIDTH'(1);
            end else begin
               abort_evt  = 1'b1;
               state_next = ST_ABORT;
            end
         end
         ST_ABORT: begin
            bus.tx_enable = 1'b1;
            bus.tx_error  = 1'b1;
            state_next    = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (rem == '0) begin
               cnt_next   = '0;
               state_next = ST_IFG;
            end else if (!bus.fifo_empty) begin
               rd       = 1'b1;
               rem_next = rem - LEN_WIDTH'(1);
            end
         end
         ST_IFG: begin
            // Last gap cycle performs the IDLE start check itself, so a queued frame's
            // preamble follows the gap directly instead of after an extra IDLE cycle.
            if (cnt == CNT_W'(IFG_NIBBLES - 1)) begin
               cnt_next = '0;
               if (start_ok) begin
                  q_pop      = 1'b1;
                  rem_next   = q_head;
                  state_next = ST_PREAMBLE;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Sticky status bits; a set event wins over status_clear.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (abort_evt)             underrun_q <= 1'b1;
         else if (bus.status_clear) underrun_q <= 1'b0;
         if (overflow_evt)          overflow_q <= 1'b1;
         else if (bus.status_clear) overflow_q <= 1'b0;
      end
   end

   assign bus.fifo_read_enable = rd;
   assign bus.queue_full       = q_full;
   assign bus.busy             = (state != ST_IDLE);
   assign bus.underrun         = underrun_q;
   assign bus.overflow         = overflow_q;

`ifdef MAC_TX_CTRL_STATS_EN
   logic        frame_done;
   logic [15:0] frames_sent_q, underruns_q;

   assign frame_done = (state == ST_DATA) && (rem == '0);

   // Saturating statistics; a clear coinciding with an event leaves a count of one.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         frames_sent_q <= '0;
         underruns_q   <= '0;
      end else begin
         if (bus.status_clear)                           frames_sent_q <= {15'd0, frame_done};
         else if (frame_done && (frames_sent_q != '1))   frames_sent_q <= frames_sent_q + 16'd1;
         if (bus.status_clear)                           underruns_q   <= {15'd0, abort_evt};
         else if (abort_evt && (underruns_q != '1))      underruns_q   <= underruns_q + 16'd1;
      end
   end

   assign bus.frames_sent = frames_sent_q;
   assign bus.underruns   = underruns_q;
`endif

endmodule

// File: tb/tb_mac_tx_fifo_ctrl.sv
// tb_mac_tx_fifo_ctrl: directed bench for the TX FIFO read scheduler with a nibble FIFO model.
module tb_mac_tx_fifo_ctrl;
   import mac_tx_pkg::*;

   localparam int unsigned LW  = 12;
   localparam int unsigned IFG = 24;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   mac_tx_fifo_ctrl_if #(.LEN_WIDTH(LW)) bus ();

   mac_tx_fifo_ctrl #(
      .LEN_WIDTH       (LW),
      .LEN_QUEUE_DEPTH (4),
      .IFG_NIBBLES     (IFG)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // TX FIFO model: registered read data, reset together with the DUT.
   logic [3:0] fmem [256];
   logic [7:0] fwr = 8'd0;
   logic [7:0] frd = 8'd0;
   logic       rd_when_empty = 1'b0;

   assign bus.fifo_empty = (fwr == frd);

   always @(posedge clock) begin
      if (!reset_n) begin
         frd           <= fwr;
         bus.fifo_data <= 4'h0;
      end else if (bus.fifo_read_enable) begin
         if (fwr == frd) begin
            rd_when_empty <= 1'b1;
         end else begin
            bus.fifo_data <= fmem[frd];
            frd           <= frd + 8'd1;
         end
      end
   end

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_nib(input logic [3:0] v);
      fmem[fwr] = v;
      fwr       = fwr + 8'd1;
   endtask

   task automatic expect_out(input string name, input logic en, input logic er, input logic [3:0] d);
      check(name, 32'({bus.tx_enable, bus.tx_error, bus.tx_data}), 32'({en, er, d}));
   endtask

   typedef struct {
      logic          commit;
      logic [LW-1:0] len;
      logic          clr;
      logic          exp_full;
      logic          exp_ovf;
   } qvec_t;

   qvec_t      qv [11];
   logic [3:0] t2d [8];
   logic [3:0] e;
   int         n;
   logic       saw_en;

   initial begin
      bus.frame_commit = 1'b0;
      bus.frame_length = '0;
      bus.status_clear = 1'b0;

      // Length-queue vectors: FIFO stays empty so the FSM never leaves IDLE.
      qv[0]  = '{1'b1, 12'd5,  1'b0, 1'b0, 1'b0};
      qv[1]  = '{1'b1, 12'd6,  1'b0, 1'b0, 1'b0};
      qv[2]  = '{1'b1, 12'd7,  1'b0, 1'b0, 1'b0};
      qv[3]  = '{1'b1, 12'd0,  1'b0, 1'b0, 1'b0};
      qv[4]  = '{1'b1, 12'd8,  1'b0, 1'b1, 1'b0};
      qv[5]  = '{1'b1, 12'd9,  1'b0, 1'b1, 1'b1};
      qv[6]  = '{1'b0, 12'd0,  1'b1, 1'b1, 1'b0};
      qv[7]  = '{1'b1, 12'd10, 1'b1, 1'b1, 1'b1};
      qv[8]  = '{1'b0, 12'd0,  1'b1, 1'b1, 1'b0};
      qv[9]  = '{1'b1, 12'd0,  1'b0, 1'b1, 1'b0};
      qv[10] = '{1'b0, 12'd0,  1'b0, 1'b1, 1'b0};

      t2d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};

      // Reset state.
      repeat (3) tick();
      expect_out("rst_tx", 1'b0, 1'b0, 4'h0);
      check("rst_busy",       32'(bus.busy), 0);
      check("rst_queue_full", 32'(bus.queue_full), 0);
      check("rst_underrun",   32'(bus.underrun), 0);
      check("rst_overflow",   32'(bus.overflow), 0);
      check("rst_read_en",    32'(bus.fifo_read_enable), 0);
      reset_n = 1'b1;
      tick();

      // Queue fill, zero-length commits, overflow and set-wins-over-clear.
      for (int i = 0; i < 11; i++) begin
         bus.frame_commit = qv[i].commit;
         bus.frame_length = qv[i].len;
         bus.status_clear = qv[i].clr;
         tick();
         bus.frame_commit = 1'b0;
         bus.status_clear = 1'b0;
         check($sformatf("qv%0d_full", i), 32'(bus.queue_full), 32'(qv[i].exp_full));
         check($sformatf("qv%0d_ovf", i),  32'(bus.overflow),   32'(qv[i].exp_ovf));
         check($sformatf("qv%0d_busy", i), 32'(bus.busy),       0);
      end

      reset_n = 1'b0;
      tick();
      check("qrst_full", 32'(bus.queue_full), 0);
      check("qrst_ovf",  32'(bus.overflow), 0);
      reset_n = 1'b1;
      tick();

      // Single 8-nibble frame.
      for (int i = 1; i <= 8; i++) push_nib(4'(i));
      bus.frame_commit = 1'b1;
      bus.frame_length = 12'd8;
      tick();
      bus.frame_commit = 1'b0;
      check("t1_idle_before", 32'(bus.busy), 0);
      tick();
      for (int i = 0; i < 24; i++) begin
         e = (i < 15) ? 4'h5 : (i == 15) ? 4'hD : 4'(i - 15);
         expect_out($sformatf("t1_tx%0d", i), 1'b1, 1'b0, e);
         tick();
      end
      for (int i = 0; i < 24; i++) begin
         expect_out($sformatf("t1_ifg%0d", i), 1'b0, 1'b0, 4'h0);
         check($sformatf("t1_ifg_busy%0d", i), 32'(bus.busy), 1);
         tick();
      end
      check("t1_done_busy", 32'(bus.busy), 0);
`ifdef MAC_TX_CTRL_STATS_EN
      check("t1_frames_sent", 32'(bus.frames_sent), 1);
`endif

      // Two 4-nibble frames back to back: preamble 25 cycles after the last nibble.
      for (int i = 0; i < 8; i++) push_nib(t2d[i]);
      bus.frame_commit = 1'b1;
      bus.frame_length = 12'd4;
      tick();
      tick();
      bus.frame_commit = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 20; i++) begin
            e = (i < 15) ? 4'h5 : (i == 15) ? 4'hD : t2d[f*4 + i - 16];
            expect_out($sformatf("t2_f%0d_tx%0d", f, i), 1'b1, 1'b0, e);
            tick();
         end
         for (int i = 0; i < 24; i++) begin
            expect_out($sformatf("t2_f%0d_ifg%0d", f, i), 1'b0, 1'b0, 4'h0);
            check($sformatf("t2_f%0d_busy%0d", f, i), 32'(bus.busy), 1);
            tick();
         end
      end
      check("t2_done_busy", 32'(bus.busy), 0);
`ifdef MAC_TX_CTRL_STATS_EN
      check("t2_frames_sent", 32'(bus.frames_sent), 3);
`endif

      // Underrun: 10-nibble frame with only 3 nibbles present.
      push_nib(4'h9);
      push_nib(4'hA);
      push_nib(4'hB);
      bus.frame_commit = 1'b1;
      bus.frame_length = 12'd10;
      tick();
      bus.frame_commit = 1'b0;
      tick();
      for (int i = 0; i < 19; i++) begin
         e = (i < 15) ? 4'h5 : (i == 15) ? 4'hD : 4'(i - 7);
         expect_out($sformatf("t3_tx%0d", i), 1'b1, 1'b0, e);
         tick();
      end
      expect_out("t3_abort", 1'b1, 1'b1, 4'h0);
      check("t3_underrun_set", 32'(bus.underrun), 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         expect_out($sformatf("t3_drain_wait%0d", i), 1'b0, 1'b0, 4'h0);
         check($sformatf("t3_drain_busy%0d", i), 32'(bus.busy), 1);
         tick();
      end
      for (int i = 0; i < 7; i++) push_nib(4'(i + 1));
      saw_en = 1'b0;
      n = 0;
      while (n < 100 && bus.busy) begin
         if (bus.tx_enable) saw_en = 1'b1;
         n++;
         tick();
      end
      check("t3_drain_to_idle", 32'(bus.busy), 0);
      check("t3_drain_cycles", 32'(n), 32);
      check("t3_drain_no_tx", 32'(saw_en), 0);
      check("t3_fifo_drained", 32'(fwr - frd), 0);
      check("t3_underrun_sticky", 32'(bus.underrun), 1);
`ifdef MAC_TX_CTRL_STATS_EN
      check("t3_underruns", 32'(bus.underruns), 1);
      check("t3_frames_sent", 32'(bus.frames_sent), 3);
`endif
      bus.status_clear = 1'b1;
      tick();
      bus.status_clear = 1'b0;
      check("t3_underrun_clr", 32'(bus.underrun), 0);
`ifdef MAC_TX_CTRL_STATS_EN
      check("t3_stats_clr", 32'({bus.frames_sent, bus.underruns}), 0);
`endif

      // Reset in the middle of DATA with a full length queue.
      for (int i = 1; i <= 6; i++) push_nib(4'(i));
      for (int i = 0; i < 5; i++) begin
         bus.frame_commit = 1'b1;
         bus.frame_length = (i == 0) ? 12'd6 : 12'd2;
         tick();
      end
      bus.frame_commit = 1'b0;
      check("t5_queue_full", 32'(bus.queue_full), 1);
      repeat (14) tick();
      expect_out("t5_mid_data", 1'b1, 1'b0, 4'h2);
      reset_n = 1'b0;
      tick();
      check("t5_rst_tx_enable", 32'(bus.tx_enable), 0);
      check("t5_rst_busy",      32'(bus.busy), 0);
      check("t5_rst_full",      32'(bus.queue_full), 0);
      check("t5_rst_tx_error",  32'(bus.tx_error), 0);
      reset_n = 1'b1;
      tick();
      check("t5_after_busy", 32'(bus.busy), 0);

      check("no_read_when_empty", 32'(rd_when_empty), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
